// File: rtl/bru_issue_queue.sv
// In-order issue queue feeding the branch resolution unit.
// Entries sit in a circular FIFO; each source tag collects its ready bit from
// the wakeup broadcast. Only the head may issue, and it issues the cycle after
// both of its ready bits are registered. The BRU never stalls, so an issued
// head is always dequeued on the following edge.
module bru_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int WK_N      = 4,
    parameter int PAYLOAD_W = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [PAYLOAD_W-1:0]     dispatch_payload,
    input  logic [TAG_W-1:0]         dispatch_src1_tag,
    input  logic [TAG_W-1:0]         dispatch_src2_tag,
    input  logic                     dispatch_src1_rdy,
    input  logic                     dispatch_src2_rdy,
    input  logic [WK_N-1:0]          wakeup_valid,
    input  logic [WK_N*TAG_W-1:0]    wakeup_tag,
    output logic                     issue_to_bru_valid,
    output logic [PAYLOAD_W-1:0]     issue_payload,
    output logic [TAG_W-1:0]         issue_src1_tag,
    output logic [TAG_W-1:0]         issue_src2_tag,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Entry storage: data fields and per-entry status bits
    logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
    logic [TAG_W-1:0]     src1_tag_q [DEPTH];
    logic [TAG_W-1:0]     src2_tag_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     rdy1_q;
    logic [DEPTH-1:0]     rdy2_q;

    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 do_push;
    logic                 do_pop;
    logic                 disp_rdy1;
    logic                 disp_rdy2;

    // True when any valid wakeup port broadcasts the given tag this cycle
    function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                     input logic [WK_N-1:0] wk_valid,
                                     input logic [WK_N*TAG_W-1:0] wk_tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WK_N; i++) begin
            if (wk_valid[i] && (wk_tag[i*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Handshakes are built from registered state only, so a dequeue in the
    // same cycle never opens a slot for that cycle's dispatch
    assign dispatch_ready     = !flush && (count_q < FULL);
    assign issue_to_bru_valid = !flush && (count_q != '0) && rdy1_q[head_q] && rdy2_q[head_q];
    assign do_push            = dispatch_valid && dispatch_ready;
    assign do_pop             = issue_to_bru_valid;
    assign disp_rdy1          = dispatch_src1_rdy || tag_hit(dispatch_src1_tag, wakeup_valid, wakeup_tag);
    assign disp_rdy2          = dispatch_src2_rdy || tag_hit(dispatch_src2_tag, wakeup_valid, wakeup_tag);

    assign issue_payload      = payload_q[head_q];
    assign issue_src1_tag     = src1_tag_q[head_q];
    assign issue_src2_tag     = src2_tag_q[head_q];
    assign queue_count        = count_q;

    // Pointers, occupancy and status bits; flush and reset empty the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && tag_hit(src1_tag_q[i], wakeup_valid, wakeup_tag)) begin
                    rdy1_q[i] <= 1'b1;
                end
                if (valid_q[i] && tag_hit(src2_tag_q[i], wakeup_valid, wakeup_tag)) begin
                    rdy2_q[i] <= 1'b1;
                end
            end
            // NOTE: several non-blocking writes may target the same bit in this
            // block; the textually last one wins, so dequeue/enqueue override
            // the wakeup updates above.
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                rdy1_q[head_q]  <= 1'b0;
                rdy2_q[head_q]  <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                rdy1_q[tail_q]  <= disp_rdy1;
                rdy2_q[tail_q]  <= disp_rdy2;
                tail_q          <= tail_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry data written at the tail on every accepted dispatch
    // NOTE: the data arrays are deliberately not reset; an entry is only ever
    // read after its valid bit (which is reset) says it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            payload_q[tail_q]  <= dispatch_payload;
            src1_tag_q[tail_q] <= dispatch_src1_tag;
            src2_tag_q[tail_q] <= dispatch_src2_tag;
        end
    end

endmodule

// File: tb/tb_bru_issue_queue.sv
// Directed bench for bru_issue_queue: inputs change 1 ns after each rising
// edge, outputs are sampled 2 ns after it, well away from the next edge.
module tb_bru_issue_queue;

    localparam int DEPTH     = 4;
    localparam int TAG_W     = 6;
    localparam int WK_N      = 4;
    localparam int PAYLOAD_W = 128;

    logic                     clk;
    logic                     reset;
    logic                     flush;
    logic                     dispatch_valid;
    logic                     dispatch_ready;
    logic [PAYLOAD_W-1:0]     dispatch_payload;
    logic [TAG_W-1:0]         dispatch_src1_tag;
    logic [TAG_W-1:0]         dispatch_src2_tag;
    logic                     dispatch_src1_rdy;
    logic                     dispatch_src2_rdy;
    logic [WK_N-1:0]          wakeup_valid;
    logic [WK_N*TAG_W-1:0]    wakeup_tag;
    logic                     issue_to_bru_valid;
    logic [PAYLOAD_W-1:0]     issue_payload;
    logic [TAG_W-1:0]         issue_src1_tag;
    logic [TAG_W-1:0]         issue_src2_tag;
    logic [$clog2(DEPTH):0]   queue_count;

    int vectors    = 0;
    int miscompares = 0;

    bru_issue_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .WK_N(WK_N), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_payload  (dispatch_payload),
        .dispatch_src1_tag (dispatch_src1_tag),
        .dispatch_src2_tag (dispatch_src2_tag),
        .dispatch_src1_rdy (dispatch_src1_rdy),
        .dispatch_src2_rdy (dispatch_src2_rdy),
        .wakeup_valid      (wakeup_valid),
        .wakeup_tag        (wakeup_tag),
        .issue_to_bru_valid(issue_to_bru_valid),
        .issue_payload     (issue_payload),
        .issue_src1_tag    (issue_src1_tag),
        .issue_src2_tag    (issue_src2_tag),
        .queue_count       (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge, then clear per-cycle inputs
    task automatic tick();
        @(posedge clk);
        #1;
        dispatch_valid    = 1'b0;
        dispatch_payload  = '0;
        dispatch_src1_tag = '0;
        dispatch_src2_tag = '0;
        dispatch_src1_rdy = 1'b0;
        dispatch_src2_rdy = 1'b0;
        wakeup_valid      = '0;
        wakeup_tag        = '0;
        flush             = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic disp(input logic [127:0] pl, input logic [TAG_W-1:0] t1, input logic r1,
                        input logic [TAG_W-1:0] t2, input logic r2);
        dispatch_valid    = 1'b1;
        dispatch_payload  = pl;
        dispatch_src1_tag = t1;
        dispatch_src1_rdy = r1;
        dispatch_src2_tag = t2;
        dispatch_src2_rdy = r2;
    endtask

    task automatic wake(input int port, input logic [TAG_W-1:0] tag, input logic vld);
        wakeup_valid[port]               = vld;
        wakeup_tag[port*TAG_W +: TAG_W]  = tag;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_payload = '0;
        dispatch_src1_tag = '0;
        dispatch_src2_tag = '0;
        dispatch_src1_rdy = 1'b0;
        dispatch_src2_rdy = 1'b0;
        wakeup_valid = '0;
        wakeup_tag = '0;

        // Reset state
        #12;
        check("rst_count", 128'(queue_count), 128'd0);
        check("rst_issue", 128'(issue_to_bru_valid), 128'd0);
        check("rst_ready", 128'(dispatch_ready), 128'd1);
        reset = 1'b0;
        tick();

        // Single ready op issues the cycle after dispatch
        disp(128'hA, 6'd1, 1'b1, 6'd2, 1'b1);
        settle();
        check("a_ready", 128'(dispatch_ready), 128'd1);
        check("a_noissue_c0", 128'(issue_to_bru_valid), 128'd0);
        tick();
        settle();
        check("a_issue", 128'(issue_to_bru_valid), 128'd1);
        check("a_payload", issue_payload, 128'hA);
        check("a_src1_tag", 128'(issue_src1_tag), 128'd1);
        check("a_count1", 128'(queue_count), 128'd1);
        tick();
        settle();
        check("a_count0", 128'(queue_count), 128'd0);
        check("a_idle", 128'(issue_to_bru_valid), 128'd0);

        // Head blocked on tag 5 holds back a ready younger entry
        disp(128'hA5, 6'd5, 1'b0, 6'd3, 1'b1);
        tick();
        disp(128'hB5, 6'd7, 1'b1, 6'd8, 1'b1);
        wake(0, 6'd6, 1'b1);    // wrong tag
        wake(1, 6'd5, 1'b0);    // right tag, port not valid
        settle();
        check("b_head_block1", 128'(issue_to_bru_valid), 128'd0);
        tick();
        wake(2, 6'd5, 1'b1);
        settle();
        check("b_head_block2", 128'(issue_to_bru_valid), 128'd0);
        check("b_count2", 128'(queue_count), 128'd2);
        tick();
        settle();
        check("b_issue_a", 128'(issue_to_bru_valid), 128'd1);
        check("b_payload_a", issue_payload, 128'hA5);
        tick();
        settle();
        check("b_issue_b", 128'(issue_to_bru_valid), 128'd1);
        check("b_payload_b", issue_payload, 128'hB5);
        check("b_count1", 128'(queue_count), 128'd1);
        tick();
        settle();
        check("b_count0", 128'(queue_count), 128'd0);

        // Same-cycle wakeup at dispatch on src1, then late wakeup on src2
        disp(128'hC9, 6'd9, 1'b0, 6'd4, 1'b1);
        wake(3, 6'd9, 1'b1);
        tick();
        settle();
        check("c_issue", 128'(issue_to_bru_valid), 128'd1);
        check("c_payload", issue_payload, 128'hC9);
        tick();
        disp(128'hD12, 6'd1, 1'b1, 6'd12, 1'b0);
        tick();
        settle();
        check("d_wait_src2", 128'(issue_to_bru_valid), 128'd0);
        wake(1, 6'd12, 1'b1);
        tick();
        settle();
        check("d_issue", 128'(issue_to_bru_valid), 128'd1);
        check("d_payload", issue_payload, 128'hD12);
        check("d_src2_tag", 128'(issue_src2_tag), 128'd12);
        tick();

        // Fill to DEPTH with a blocked head
        disp(128'hE0, 6'd20, 1'b0, 6'd0, 1'b1);
        tick();
        disp(128'hE1, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        disp(128'hE2, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        disp(128'hE3, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        disp(128'hEE, 6'd0, 1'b1, 6'd0, 1'b1);   // refused: queue full
        settle();
        check("e_full_count", 128'(queue_count), 128'd4);
        check("e_full_ready", 128'(dispatch_ready), 128'd0);
        check("e_full_noissue", 128'(issue_to_bru_valid), 128'd0);
        tick();
        wake(0, 6'd20, 1'b1);
        settle();
        check("e_still_full", 128'(queue_count), 128'd4);
        tick();
        settle();
        check("e_issue_e0", 128'(issue_to_bru_valid), 128'd1);
        check("e_payload_e0", issue_payload, 128'hE0);
        check("e_ready_during_pop", 128'(dispatch_ready), 128'd0);
        tick();
        settle();
        check("e_ready_after_pop", 128'(dispatch_ready), 128'd1);
        check("e_count3", 128'(queue_count), 128'd3);
        check("e_payload_e1", issue_payload, 128'hE1);
        tick();
        settle();
        check("e_payload_e2", issue_payload, 128'hE2);
        tick();
        settle();
        check("e_payload_e3", issue_payload, 128'hE3);
        tick();
        settle();
        check("e_drained", 128'(queue_count), 128'd0);

        // Flush with a ready head and a concurrent dispatch
        disp(128'hF0, 6'd30, 1'b0, 6'd0, 1'b1);
        tick();
        disp(128'hF1, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        disp(128'hF2, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        wake(2, 6'd30, 1'b1);
        settle();
        check("f_count3", 128'(queue_count), 128'd3);
        tick();
        flush = 1'b1;
        disp(128'hFF, 6'd0, 1'b1, 6'd0, 1'b1);
        settle();
        check("f_issue_suppr", 128'(issue_to_bru_valid), 128'd0);
        check("f_ready_suppr", 128'(dispatch_ready), 128'd0);
        tick();
        settle();
        check("f_count0", 128'(queue_count), 128'd0);
        check("f_noissue", 128'(issue_to_bru_valid), 128'd0);
        check("f_ready_back", 128'(dispatch_ready), 128'd1);
        disp(128'h77, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        settle();
        check("f_after_payload", issue_payload, 128'h77);
        check("f_after_count", 128'(queue_count), 128'd1);
        tick();

        // Ten back-to-back ready dispatches wrap the pointers
        for (int k = 0; k < 10; k++) begin
            disp(128'h100 + 128'(k), 6'd0, 1'b1, 6'd0, 1'b1);
            settle();
            if (k > 0) begin
                check("g_issue", 128'(issue_to_bru_valid), 128'd1);
                check("g_payload", issue_payload, 128'h100 + 128'(k - 1));
                check("g_count", 128'(queue_count), 128'd1);
            end
            tick();
        end
        settle();
        check("g_last_payload", issue_payload, 128'h109);
        check("g_last_count", 128'(queue_count), 128'd1);
        tick();
        settle();
        check("g_empty", 128'(queue_count), 128'd0);

        // Asynchronous reset mid-cycle discards queued state
        disp(128'h55, 6'd40, 1'b0, 6'd0, 1'b1);
        tick();
        reset = 1'b1;
        settle();
        check("r_async_count", 128'(queue_count), 128'd0);
        check("r_async_ready", 128'(dispatch_ready), 128'd1);
        tick();
        reset = 1'b0;
        tick();
        settle();
        check("r_after_count", 128'(queue_count), 128'd0);
        check("r_after_issue", 128'(issue_to_bru_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bru_issue_queue.md
BRU_ISSUE_QUEUE -- requirements
Module: bru_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 6, meaning physical-register tag width.
REQ-003 SHALL have parameter WK_N, default 4, meaning number of wakeup broadcast ports.
REQ-004 SHALL have parameter PAYLOAD_W, default 128, meaning opaque decoded-branch payload width (inst, pc, rob_entry_num, bpu_entry, br_taken, phy_dest).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, pipeline flush from commit.
REQ-008 SHALL have port dispatch_valid, input, 1, a branch op is offered.
REQ-009 SHALL have port dispatch_ready, output, 1, queue accepts the op this cycle.
REQ-010 SHALL have port dispatch_payload, input, PAYLOAD_W, op payload.
REQ-011 SHALL have ports dispatch_src1_tag/dispatch_src2_tag, input, TAG_W each, source tags.
REQ-012 SHALL have ports dispatch_src1_rdy/dispatch_src2_rdy, input, 1 each, source already available at dispatch.
REQ-013 SHALL have port wakeup_valid, input, WK_N, per-port broadcast valid.
REQ-014 SHALL have port wakeup_tag, input, WK_N*TAG_W, per-port produced tag (port i at bits [i*TAG_W +: TAG_W]).
REQ-015 SHALL have port issue_to_bru_valid, output, 1, head op issued this cycle.
REQ-016 SHALL have port issue_payload, output, PAYLOAD_W, head payload.
REQ-017 SHALL have ports issue_src1_tag/issue_src2_tag, output, TAG_W each, head source tags for register read.
REQ-018 SHALL have port queue_count, output, $clog2(DEPTH)+1, occupied entries.

Function
REQ-019 SHALL be an in-order circular FIFO; head pointer, tail pointer, count; pointers wrap from DEPTH-1 to 0.
REQ-020 SHALL assert dispatch_ready = !flush && (count < DEPTH), from registered count only; a same-cycle issue does not free a slot for that cycle's dispatch.
REQ-021 SHALL write an entry at tail when dispatch_valid && dispatch_ready; per-source ready bit = dispatch_srcN_rdy OR any same-cycle wakeup_valid[i] with wakeup_tag[i] == dispatch_srcN_tag.
REQ-022 SHALL, every cycle, set the ready bit of every valid entry source whose tag matches any valid wakeup port; bits never clear except by dequeue, flush, or reset.
REQ-023 SHALL assert issue_to_bru_valid = !flush && count != 0 && head src1 ready bit && head src2 ready bit, using registered ready bits only (wakeup-to-issue latency exactly 1 cycle).
REQ-024 SHALL dequeue head on the edge ending any cycle where issue_to_bru_valid is 1; BRU has no backpressure.
REQ-025 SHALL never issue a younger entry before the head, even if the younger entry is ready.
REQ-026 SHALL drive issue_payload/issue_src*_tag from head entry regardless of valid; value undefined when count==0.
REQ-027 SHALL, on simultaneous dispatch and issue, update count by +1-1 = unchanged and move both pointers.
REQ-028 SHALL, when flush is 1, on the next edge, clear all valid/ready bits, head=tail=0, count=0; dispatch and issue in the flush cycle are both suppressed.
REQ-029 SHALL drive queue_count = registered count; dispatch-to-earliest-issue latency is 1 cycle (entry written at edge N, issue_to_bru_valid high in cycle N+1 if ready).

Reset
REQ-030 SHALL, while reset is high (asynchronously), force head=tail=0, count=0, all entry valid/ready bits 0; hence issue_to_bru_valid=0, queue_count=0, dispatch_ready=1 when flush=0.
REQ-031 SHALL discard any in-flight dispatch or issue when reset asserts mid-operation; first legal dispatch is the first edge after reset deasserts.

Verification
REQ-032 SHALL pass: dispatch op A with src1_rdy=src2_rdy=1 at edge 0 -> issue_to_bru_valid=1 cycle 1 with A payload, queue_count 1->0 at edge 1.
REQ-033 SHALL pass: dispatch A(src1 tag 5 not ready), B(all ready) -> neither issues; wakeup tag 5 in cycle 3 -> A issues cycle 4, B cycle 5.
REQ-034 SHALL pass: dispatch tag 9 not ready with wakeup tag 9 same cycle -> entry ready, issues next cycle.
REQ-035 SHALL pass: fill 4 entries, head not ready -> dispatch_ready=0, queue_count=4; wake head -> issue; dispatch_ready returns 1 only the cycle after dequeue.
REQ-036 SHALL pass: 3 entries queued, flush=1 with dispatch_valid=1 -> issue_to_bru_valid=0 that cycle, queue_count=0 next cycle, dispatched op lost.
REQ-037 SHALL pass: 10 back-to-back ready dispatches -> pointer wrap, one issue per cycle, payloads in dispatch order, count steady at 1.
